// File: rtl/matmul_feeder_pkg.sv
// Shared constants for the matrix-multiplier feeder: default geometry, bus widths
// and the sequencer state encoding.
package matmul_feeder_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_OUTPUT_WIDTH = 8;
  localparam int DEF_MAC_NUM      = 8;
  localparam int DEF_K_MAX        = 16;

  // Counter width able to hold every value 0..k_max inclusive.
  function automatic int calc_kw(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  localparam int KW    = calc_kw(DEF_K_MAX);
  localparam int DIN_W = DEF_DATA_WIDTH * DEF_MAC_NUM;
  localparam int RES_W = DEF_OUTPUT_WIDTH * DEF_MAC_NUM;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_CLEAR  = CLEAR,
    ST_STREAM = STREAM,
    ST_WAIT   = WAIT,
    ST_OUT    = OUT
  } state_e;

endpackage

// File: rtl/matmul_feeder_if.sv
// Command, operand-source, multiplier and result signals of the feeder.
// The slave modport is the feeder's view; master is the surrounding system.
interface matmul_feeder_if #(
  parameter int DATA_WIDTH   = matmul_feeder_pkg::DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = matmul_feeder_pkg::DEF_WEIGHT_WIDTH,
  parameter int OUTPUT_WIDTH = matmul_feeder_pkg::DEF_OUTPUT_WIDTH,
  parameter int MAC_NUM      = matmul_feeder_pkg::DEF_MAC_NUM,
  parameter int K_MAX        = matmul_feeder_pkg::DEF_K_MAX
);

  localparam int IF_KW    = matmul_feeder_pkg::calc_kw(K_MAX);
  localparam int IF_DIN_W = DATA_WIDTH * MAC_NUM;
  localparam int IF_RES_W = OUTPUT_WIDTH * MAC_NUM;

  logic                    start_i;
  logic [IF_KW-1:0]        k_len_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [IF_DIN_W-1:0]     s_din_i;
  logic [WEIGHT_WIDTH-1:0] s_win_i;
  logic                    mm_en_o;
  logic                    mm_clear_o;
  logic                    mm_valid_o;
  logic [IF_DIN_W-1:0]     mm_din_o;
  logic [WEIGHT_WIDTH-1:0] mm_win_o;
  logic                    mm_done_i;
  logic [IF_RES_W-1:0]     mm_result_i;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic [IF_RES_W-1:0]     m_result_o;
  logic                    busy_o;
  logic                    err_o;

  modport slave (
    input  start_i, k_len_i, s_valid_i, s_din_i, s_win_i,
    input  mm_done_i, mm_result_i, m_ready_i,
    output s_ready_o, mm_en_o, mm_clear_o, mm_valid_o, mm_din_o, mm_win_o,
    output m_valid_o, m_result_o, busy_o, err_o
  );

  modport master (
    output start_i, k_len_i, s_valid_i, s_din_i, s_win_i,
    output mm_done_i, mm_result_i, m_ready_i,
    input  s_ready_o, mm_en_o, mm_clear_o, mm_valid_o, mm_din_o, mm_win_o,
    input  m_valid_o, m_result_o, busy_o, err_o
  );

endinterface

// File: rtl/matmul_feeder.sv
// Job sequencer in front of the matrix multiplier: clear accumulators, stream
// k operand beats, wait for done, then hold the captured result until taken.
module matmul_feeder
  import matmul_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int MAC_NUM      = DEF_MAC_NUM,
  parameter int K_MAX        = DEF_K_MAX
) (
  input  logic           clk_i,
  input  logic           rst_i,
  matmul_feeder_if.slave bus
);

  localparam int               CNT_W     = calc_kw(K_MAX);
  localparam int               BUS_DIN_W = DATA_WIDTH * MAC_NUM;
  localparam int               BUS_RES_W = OUTPUT_WIDTH * MAC_NUM;
  localparam logic [CNT_W-1:0] K_MAX_C   = CNT_W'(K_MAX);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    r_mm_valid;
  logic                    r_err;
  logic [BUS_DIN_W-1:0]    r_mm_din;
  logic [WEIGHT_WIDTH-1:0] r_mm_win;
  logic [BUS_RES_W-1:0]    r_result;

  logic w_len_ok;
  logic w_start_ok;
  logic w_start_bad;
  logic w_accept;
  logic w_capture;
  logic w_s_ready;
  logic w_mm_en;
  logic w_mm_clear;

  // A start is only meaningful in IDLE; anywhere else it is silently dropped.
  assign w_len_ok    = (bus.k_len_i != '0) && (bus.k_len_i <= K_MAX_C);
  assign w_start_ok  = (r_state == ST_IDLE) && bus.start_i && w_len_ok;
  assign w_start_bad = (r_state == ST_IDLE) && bus.start_i && !w_len_ok;
  assign w_accept    = w_s_ready && bus.s_valid_i;
  assign w_capture   = (r_state == ST_WAIT) && bus.mm_done_i;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_mm_en     = 1'b0;
    w_mm_clear  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_mm_clear  = 1'b1;
        w_mm_en     = 1'b1;
        w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        w_s_ready = 1'b1;
        w_mm_en   = 1'b1;
        if (bus.s_valid_i && (w_cnt_inc == r_len)) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_mm_en = 1'b1;
        if (bus.mm_done_i) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (bus.m_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the wide operand/result registers are plain flops, not a memory,
  // so they take the async reset and read as zero after any reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_mm_valid <= 1'b0;
      r_err      <= 1'b0;
      r_mm_din   <= '0;
      r_mm_win   <= '0;
      r_result   <= '0;
    end else begin
      r_err      <= w_start_bad;
      r_mm_valid <= w_accept;
      if (w_start_ok) r_len <= bus.k_len_i;
      if (r_state == ST_CLEAR) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_accept) begin
        r_mm_din <= bus.s_din_i;
        r_mm_win <= bus.s_win_i;
      end
      if (w_capture) r_result <= bus.mm_result_i;
    end
  end

  assign bus.s_ready_o  = w_s_ready;
  assign bus.mm_en_o    = w_mm_en;
  assign bus.mm_clear_o = w_mm_clear;
  assign bus.mm_valid_o = r_mm_valid;
  assign bus.mm_din_o   = r_mm_din;
  assign bus.mm_win_o   = r_mm_win;
  assign bus.m_valid_o  = (r_state == ST_OUT);
  assign bus.m_result_o = r_result;
  assign bus.busy_o     = (r_state != ST_IDLE);
  assign bus.err_o      = r_err;

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder: the driver models each job as a list of
// expected operand beats and one expected result; a monitor checks them as they appear.
module tb_matmul_feeder;
  import matmul_feeder_pkg::*;

  localparam int BEAT_W = DIN_W + DEF_WEIGHT_WIDTH;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  matmul_feeder_if bus ();

  matmul_feeder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [BEAT_W-1:0] exp_beats[$];
  logic [RES_W-1:0]  exp_results[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DIN_W-1:0] make_din(input int b);
    logic [DIN_W-1:0] d;
    d = '0;
    for (int i = 0; i < DEF_MAC_NUM; i++) d[i*DEF_DATA_WIDTH +: DEF_DATA_WIDTH] = 8'(b * 8 + i);
    return d;
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[BEAT_W-1:0];
  endfunction

  function automatic logic [RES_W-1:0] rand_res();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: every presented operand beat and every taken result must match the queue head.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.mm_valid_o) begin
        check("mm_beat_pending", 128'(exp_beats.size() != 0), 128'(1));
        if (exp_beats.size() != 0) begin
          logic [BEAT_W-1:0] e;
          e = exp_beats.pop_front();
          check("mm_beat", {bus.mm_din_o, bus.mm_win_o}, e);
        end
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        check("result_pending", 128'(exp_results.size() != 0), 128'(1));
        if (exp_results.size() != 0) begin
          logic [RES_W-1:0] e;
          e = exp_results.pop_front();
          check("result", bus.m_result_o, e);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {bus.s_ready_o, bus.mm_en_o, bus.mm_clear_o, bus.mm_valid_o,
                           bus.m_valid_o, bus.busy_o, bus.err_o}, '0);
    check({tag, "_mm_data"}, {bus.mm_din_o, bus.mm_win_o}, '0);
    check({tag, "_result"}, bus.m_result_o, '0);
  endtask

  // vmode: 0 full rate, 1 alternating 1,0,1,..., 2 random valid with start_i held high while streaming.
  task automatic run_job(input int k, input int vmode, input bit spec_data, input int lat,
                         input int stall, input bit stray, input logic [RES_W-1:0] res,
                         input bit extra_beat);
    int                acc   = 0;
    int                guard = 0;
    bit                v;
    bit                prev  = 1'b0;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] last  = '0;

    check("idle_busy", bus.busy_o, 0);
    bus.start_i = 1'b1;
    bus.k_len_i = KW'(k);
    cyc();
    bus.start_i = 1'b0;
    check("clear_pulse", bus.mm_clear_o, 1);
    check("clear_en", bus.mm_en_o, 1);
    check("clear_ready", bus.s_ready_o, 0);
    check("clear_busy", bus.busy_o, 1);
    cyc();

    while (acc < k && guard < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      beat = spec_data ? {make_din(acc), 8'(acc + 1)} : rand_beat();
      bus.s_valid_i = v;
      {bus.s_din_i, bus.s_win_i} = beat;
      bus.start_i = (vmode == 2);
      bus.k_len_i = (vmode == 2) ? KW'(3) : KW'(k);
      check("stream_ready", bus.s_ready_o, 1);
      check("stream_en", bus.mm_en_o, 1);
      check("stream_no_clear", bus.mm_clear_o, 0);
      check("stream_no_err", bus.err_o, 0);
      check("mm_valid_timing", bus.mm_valid_o, prev);
      if (acc > 0) check("mm_hold", {bus.mm_din_o, bus.mm_win_o}, last);
      if (v) begin
        exp_beats.push_back(beat);
        last = beat;
        acc++;
      end
      prev = v;
      guard++;
      cyc();
    end
    check("stream_guard", 128'(acc), 128'(k));

    // First WAIT cycle: ready must already be low; an extra offered beat must be refused.
    bus.start_i   = 1'b0;
    bus.s_valid_i = extra_beat;
    {bus.s_din_i, bus.s_win_i} = rand_beat();
    check("wait_ready_low", bus.s_ready_o, 0);
    check("last_mm_valid", bus.mm_valid_o, 1);
    check("wait_en", bus.mm_en_o, 1);
    check("wait_no_err", bus.err_o, 0);
    cyc();
    bus.s_valid_i = 1'b0;
    check("wait_mm_valid_low", bus.mm_valid_o, 0);
    for (int i = 0; i < lat; i++) begin
      check("wait_no_result", bus.m_valid_o, 0);
      check("wait_en_hold", bus.mm_en_o, 1);
      check("wait_busy", bus.busy_o, 1);
      cyc();
    end

    bus.mm_done_i   = 1'b1;
    bus.mm_result_i = res;
    exp_results.push_back(res);
    cyc();
    bus.mm_done_i   = 1'b0;
    bus.mm_result_i = ~res;
    check("out_valid", bus.m_valid_o, 1);
    check("out_result", bus.m_result_o, res);
    check("out_en_low", bus.mm_en_o, 0);
    check("out_busy", bus.busy_o, 1);

    for (int i = 0; i < stall; i++) begin
      bus.m_ready_i = 1'b0;
      bus.mm_done_i = stray && (i == 1);
      cyc();
      check("stall_valid", bus.m_valid_o, 1);
      check("stall_result", bus.m_result_o, res);
    end
    bus.mm_done_i = 1'b0;

    // Handshake with a coinciding (ignored) start.
    bus.m_ready_i = 1'b1;
    bus.start_i   = 1'b1;
    bus.k_len_i   = KW'(1);
    cyc();
    bus.m_ready_i = 1'b0;
    bus.start_i   = 1'b0;
    check("post_busy", bus.busy_o, 0);
    check("post_m_valid", bus.m_valid_o, 0);
    cyc();
    check("post_no_clear", bus.mm_clear_o, 0);
    check("post_idle", bus.busy_o, 0);
    check("beats_drained", 128'(exp_beats.size()), 128'(0));
    check("results_drained", 128'(exp_results.size()), 128'(0));
  endtask

  task automatic reject(input int k);
    bus.start_i = 1'b1;
    bus.k_len_i = KW'(k);
    cyc();
    bus.start_i = 1'b0;
    check("rej_err", bus.err_o, 1);
    check("rej_busy", bus.busy_o, 0);
    check("rej_no_clear", bus.mm_clear_o, 0);
    cyc();
    check("rej_err_pulse", bus.err_o, 0);
    check("rej_still_idle", bus.busy_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i           = 1'b1;
    bus.start_i     = 1'b0;
    bus.k_len_i     = '0;
    bus.s_valid_i   = 1'b0;
    bus.s_din_i     = '0;
    bus.s_win_i     = '0;
    bus.mm_done_i   = 1'b0;
    bus.mm_result_i = '0;
    bus.m_ready_i   = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    rst_i = 1'b0;
    cyc();

    // Basic job with the reference lane pattern and result.
    run_job(4, 0, 1'b1, 2, 0, 1'b0, 64'h0807060504030201, 1'b0);
    // Gapped source 1,0,1,0,1.
    run_job(3, 1, 1'b0, 1, 0, 1'b0, rand_res(), 1'b0);
    // Rejected starts.
    reject(0);
    reject(DEF_K_MAX + 1);
    // Start held high throughout STREAM is ignored.
    run_job(5, 2, 1'b0, 0, 1, 1'b0, rand_res(), 1'b0);
    // Result backpressure with a stray done.
    run_job(2, 0, 1'b0, 3, 5, 1'b1, rand_res(), 1'b0);

    // Reset in the middle of a 4-beat job, after 2 beats.
    bus.start_i = 1'b1;
    bus.k_len_i = KW'(4);
    cyc();
    bus.start_i = 1'b0;
    cyc();
    for (int b = 0; b < 2; b++) begin
      logic [BEAT_W-1:0] beat;
      beat = rand_beat() | BEAT_W'(1);
      bus.s_valid_i = 1'b1;
      {bus.s_din_i, bus.s_win_i} = beat;
      exp_beats.push_back(beat);
      cyc();
    end
    bus.s_valid_i = 1'b0;
    check("pre_rst_valid", bus.mm_valid_o, 1);
    check("pre_rst_busy", bus.busy_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_beats.delete();
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();
    run_job(1, 0, 1'b0, 0, 0, 1'b0, rand_res(), 1'b0);

    // Maximum length at full rate, with an extra beat offered afterwards.
    run_job(DEF_K_MAX, 0, 1'b0, 0, 0, 1'b0, rand_res(), 1'b1);

    for (int j = 0; j < 8; j++) begin
      int st;
      st = $urandom_range(0, 4);
      run_job($urandom_range(1, DEF_K_MAX), $urandom_range(0, 2), 1'b0, $urandom_range(0, 4),
              st, (st >= 2), rand_res(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_feeder.md
# matmul_feeder

Sequencer that sits directly upstream of the matrix multiplier and drives its control and operand ports. On a start command it clears the MAC accumulators, then streams `k_len_i` operand beats (one `MAC_NUM`-lane data vector plus one shared weight per beat) from a valid/ready source. It then waits for the multiplier's done, captures the `MAC_NUM`-lane result, and holds it on a valid/ready result port until it is taken.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one data lane.
- `WEIGHT_WIDTH`, 8: width of the shared weight.
- `OUTPUT_WIDTH`, 8: width of one result lane.
- `MAC_NUM`, 8: lane count.
- `K_MAX`, 16: maximum reduction length. `KW = $clog2(K_MAX+1)`.

Ports:
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start command; sampled only in IDLE.
- `k_len_i`  in  KW  number of beats for this job; sampled with `start_i`.
- `s_valid_i`  in  1  operand beat valid.
- `s_ready_o`  out  1  operand beat ready.
- `s_din_i`  in  DATA_WIDTH*MAC_NUM  lane vector; lane i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_win_i`  in  WEIGHT_WIDTH  weight for this beat.
- `mm_en_o`  out  1  multiplier enable.
- `mm_clear_o`  out  1  accumulator clear.
- `mm_valid_o`  out  1  operand valid to the multiplier.
- `mm_din_o`  out  DATA_WIDTH*MAC_NUM  registered lane vector.
- `mm_win_o`  out  WEIGHT_WIDTH  registered weight.
- `mm_done_i`  in  1  multiplier done (already registered by the multiplier).
- `mm_result_i`  in  OUTPUT_WIDTH*MAC_NUM  multiplier result.
- `m_valid_o`  out  1  result valid.
- `m_ready_i`  in  1  result ready.
- `m_result_o`  out  OUTPUT_WIDTH*MAC_NUM  captured result.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_o`  out  1  one-cycle pulse when a start is rejected.

## Operation
- **Reset.** All outputs reset to 0, the state resets to IDLE and the beat counter resets to 0.
- **IDLE.**
  - `start_i=1` with `1 ≤ k_len_i ≤ K_MAX`: latch `k_len_i` and go to CLEAR.
  - `start_i=1` with `k_len_i=0` or `k_len_i>K_MAX`: pulse `err_o` and stay in IDLE.
- **CLEAR** (one cycle): `mm_clear_o=1`, `mm_en_o=1`, counter set to 0, then go to STREAM.
- **STREAM.**
  - `s_ready_o=1`.
  - On each `s_valid_i && s_ready_o` handshake: register `s_din_i` and `s_win_i` onto `mm_din_o` and `mm_win_o`, assert `mm_valid_o` in the next cycle for exactly one cycle, and increment the counter.
  - The beat that makes the count equal the latched length moves the state to WAIT. `s_ready_o` drops in that same next cycle, so no extra beat can be accepted.
  - No accepted beat in a cycle means `mm_valid_o=0` in the following cycle. `mm_din_o` and `mm_win_o` hold their last values.
- **WAIT.**
  - `mm_en_o=1`, `s_ready_o=0`.
  - On `mm_done_i=1`, capture `mm_result_i` into `m_result_o` and go to OUT.
- **OUT.**
  - `m_valid_o=1` and `m_result_o` are held stable until `m_ready_i=1`.
  - On the handshake, go to IDLE.
  - `start_i` is ignored in OUT, even when it coincides with the handshake.
- **Enable.** `mm_en_o` is high in CLEAR, STREAM and WAIT, and low in IDLE and OUT.
- **Stray done.** `mm_done_i` in any state other than WAIT is ignored.
- **Start while busy.** `start_i` while busy is ignored without an error pulse.
- **Datapath.** Operands and the result pass through unmodified. There is no arithmetic on the datapath, and lane order is preserved bit-exactly.

## Timing
- `start_i` to `mm_clear_o`: 1 cycle. `mm_clear_o` to first `s_ready_o`: 1 cycle.
- Accepted beat to `mm_valid_o`: 1 cycle, registered. Full-rate streaming sustains 1 beat per cycle.
- `mm_done_i` to `m_valid_o`: 1 cycle.
- Result handshake to IDLE: 1 cycle. Earliest next `mm_clear_o` is 2 cycles after the handshake.
- Minimum job time with no stalls: 1 + 1 + k + (multiplier latency) + 1 cycles.
- Reset asserted mid-job:
  - All outputs go to 0 immediately, asynchronously, and any partial job is discarded.
  - After reset deasserts, the first `start_i` starts a clean job.

## Structure
- **Shared package:**
  - state encoding localparams: IDLE=0, CLEAR=1, STREAM=2, WAIT=3, OUT=4, 3 bits;
  - `KW` derivation;
  - bus-width helper constants `DIN_W = DATA_WIDTH*MAC_NUM` and `RES_W = OUTPUT_WIDTH*MAC_NUM`, shared with the multiplier.
- **Sub-modules:** none needed. Keep the FSM, beat counter and operand/result registers in one module of roughly 150–250 lines.

## Test plan
- **Basic job.** `k_len=4`, four back-to-back beats with lane i of beat b = b*8+i and weight = b+1.
  - Required: one `mm_clear_o` pulse, then four consecutive `mm_valid_o` cycles with matching `mm_din_o`/`mm_win_o`.
  - Required: `mm_done_i` with result 0x0807060504030201 gives `m_valid_o` 1 cycle later with that value.
- **Gapped source.** `k_len=3`, `s_valid_i` toggling 1,0,1,0,1.
  - Required: `mm_valid_o` pulses exactly 3 times, each 1 cycle after its handshake.
  - Required: `s_ready_o` is low in the cycle after the third beat.
- **Rejected and ignored starts.**
  - `start_i` with `k_len_i=0`, or with `k_len_i=K_MAX+1` (=17): `err_o` pulses once and `busy_o` stays 0.
  - `start_i` during STREAM: no effect and no `err_o`.
- **Result backpressure.** `m_ready_i` held low for 5 cycles in OUT.
  - Required: `m_valid_o` and `m_result_o` stay stable.
  - Required: `mm_done_i` pulsed again during the stall is ignored, and the result is unchanged.
- **Reset mid-STREAM.** Assert `rst_i` after 2 of 4 beats.
  - Required: all outputs go to 0 asynchronously.
  - Required: a subsequent `k_len=1` job completes normally with a fresh clear.
- **Maximum length.** `k_len=K_MAX` (=16) at full rate.
  - Required: 16 `mm_valid_o` cycles, no dropped or extra beats, and the counter does not wrap.
